// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and constants for the HC-SR04 ranger block.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ultra_pkg;

    // Width of the published echo count and its saturated (out-of-range) value
    localparam int COUNT_W = 20;
    localparam logic [COUNT_W-1:0] COUNT_SAT = 20'hFFFFF;

    // Measurement-cycle FSM states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLD      = 3'd4
    } state_t;

endpackage

// File: rtl/ultrasonic_ranger_sync2.sv
// Two-flop synchronizer for an asynchronous sensor input.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; samples every cycle.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; the first stage may go metastable, the second settles it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Free-running HC-SR04 driver: trigger, time the echo pulse, publish a held count.
// Latency: echo seen 2 cycles late (synchronizer); result registered on HOLD entry.
// Backpressure: none; valid is a one-cycle pulse, count holds until the next result.
module ultrasonic_ranger
    import ultra_pkg::*;
#(
    parameter int TRIG_CYC     = 500,
    parameter int RISE_TO_CYC  = 50000,
    parameter int MAX_ECHO_CYC = 1000000,
    parameter int PERIOD_CYC   = 3000000,
    parameter int TW           = 22
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               echo,
    output logic               trig,
    output logic [COUNT_W-1:0] count,
    output logic               valid,
    output logic               timeout,
    output logic               busy
);

    localparam logic [TW-1:0]      TRIG_LAST = TW'(TRIG_CYC - 1);
    localparam logic [TW-1:0]      RISE_LAST = TW'(RISE_TO_CYC - 1);
    localparam logic [TW-1:0]      PER_LAST  = TW'(PERIOD_CYC - 1);
    localparam logic [COUNT_W-1:0] ECHO_MAX  = COUNT_W'(MAX_ECHO_CYC);

    state_t             state;
    state_t             state_nxt;
    logic [TW-1:0]      per;
    logic [TW-1:0]      ph;
    logic [COUNT_W-1:0] ec;
    logic               echo_s;
    logic               commit_good;
    logic               commit_to;

    sync2 u_echo_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (echo),
        .q     (echo_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and result-commit strobes
    always_comb begin
        state_nxt   = state;
        commit_good = 1'b0;
        commit_to   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = TRIG;
                end
            end
            TRIG: begin
                if (ph == TRIG_LAST) begin
                    state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                // A rise seen on the last allowed cycle still wins over the timeout
                if (echo_s) begin
                    state_nxt = MEASURE;
                end else if (ph == RISE_LAST) begin
                    state_nxt = HOLD;
                    commit_to = 1'b1;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_nxt   = HOLD;
                    commit_good = 1'b1;
                end else if (ec >= ECHO_MAX) begin
                    state_nxt = HOLD;
                    commit_to = 1'b1;
                end
            end
            HOLD: begin
                if (per == PER_LAST) begin
                    state_nxt = en ? TRIG : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Period timer restarts on TRIG entry; phase timer restarts on every transition
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per <= '0;
            ph  <= '0;
        end else begin
            if (state_nxt == TRIG && state != TRIG) begin
                per <= '0;
            end else begin
                per <= per + 1'b1;
            end
            if (state_nxt != state) begin
                ph <= '0;
            end else begin
                ph <= ph + 1'b1;
            end
        end
    end

    // Echo width counter: the rising sample counts as 1, each further high sample adds 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ec <= '0;
        end else if (state == WAIT_RISE && echo_s) begin
            ec <= COUNT_W'(1);
        end else if (state == MEASURE && echo_s && ec < ECHO_MAX && ec != COUNT_SAT) begin
            ec <= ec + 1'b1;
        end
    end

    // Registered outputs: trig/busy follow the next state, results commit on HOLD entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig    <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            trig  <= (state_nxt == TRIG);
            busy  <= (state_nxt != IDLE);
            valid <= commit_good | commit_to;
            if (commit_good) begin
                count   <= ec;
                timeout <= 1'b0;
            end else if (commit_to) begin
                count   <= COUNT_SAT;
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger with shortened timing parameters.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ultrasonic_ranger;

    localparam int TRIG = 10;
    localparam int RISE = 100;
    localparam int MAXE = 1000;
    localparam int PER  = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        echo;
    logic        trig;
    logic [19:0] count;
    logic        valid;
    logic        timeout;
    logic        busy;

    int          pass_cnt   = 0;
    int          total_cnt  = 0;
    int          cyc        = 0;
    int          hi_run     = 0;
    int          valid_seen = 0;
    int          last_rise  = -1;
    logic [19:0] prev_count = '0;

    typedef struct {
        int          d;      // echo start, cycles relative to first WAIT_RISE cycle
        int          w;      // echo width in cycles (0 = no echo)
        logic [19:0] count;
        logic        to;
    } vec_t;

    vec_t tbl [10];

    ultrasonic_ranger #(
        .TRIG_CYC     (TRIG),
        .RISE_TO_CYC  (RISE),
        .MAX_ECHO_CYC (MAXE),
        .PERIOD_CYC   (PER),
        .TW           (22)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .echo    (echo),
        .trig    (trig),
        .count   (count),
        .valid   (valid),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Trigger pulse width and valid pulse tally, sampled mid-cycle
    always @(negedge clk) begin
        if (trig === 1'b1) begin
            hi_run++;
        end else begin
            if (hi_run != 0) check("trig_width", hi_run, TRIG);
            hi_run = 0;
        end
        if (valid === 1'b1) valid_seen++;
    end

    // Reference: synchronized echo is high on relative cycles [d+2, d+w+1]; the FSM
    // looks for it on relative cycles [0, RISE-1] and counts every high sample from
    // the first one it sees, timing out beyond MAXE samples.
    function automatic void model(input int d, input int w,
                                  output logic [19:0] c, output logic to);
        int first, last, start, n;
        c  = 20'hFFFFF;
        to = 1'b1;
        if (w > 0) begin
            first = d + 2;
            last  = d + w + 1;
            start = (first < 0) ? 0 : first;
            if (last >= start && start <= RISE - 1) begin
                n = last - start + 1;
                if (n <= MAXE) begin
                    c  = 20'(n);
                    to = 1'b0;
                end
            end
        end
    endfunction

    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (trig === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One measurement cycle: sync to trig rise, drive the echo, check the committed result
    task automatic run_meas(input int d, input int w, input bit drop_en,
                            input logic [19:0] ecount, input logic eto, input string tag);
        bit ok;
        bit got;
        wait_rise(ok);
        check({tag, "_trig_rise"}, 32'(ok), 1);
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_count_held"}, 32'(count), 32'(prev_count));
        if (last_rise >= 0) check({tag, "_period"}, cyc - last_rise, PER);
        last_rise = cyc;
        fork
            begin
                if (w > 0) begin
                    if (d + TRIG > 0) begin
                        repeat (d + TRIG) @(posedge clk);
                        #1;
                    end
                    echo = 1'b1;
                    if (drop_en) begin
                        repeat (w / 2) @(posedge clk);
                        #1 en = 1'b0;
                        repeat (w - w / 2) @(posedge clk);
                    end else begin
                        repeat (w) @(posedge clk);
                    end
                    #1 echo = 1'b0;
                end
            end
            begin
                got = 1'b0;
                for (int i = 0; i < 4000; i++) begin
                    @(negedge clk);
                    if (valid === 1'b1) begin
                        got = 1'b1;
                        break;
                    end
                end
                check({tag, "_valid_seen"}, 32'(got), 1);
                check({tag, "_count"}, 32'(count), 32'(ecount));
                check({tag, "_timeout"}, 32'(timeout), 32'(eto));
                @(negedge clk);
                check({tag, "_valid_1cyc"}, 32'(valid), 0);
            end
        join
        prev_count = ecount;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] mc;
        logic        mt;
        bit          ok;
        int          d;
        int          w;
        int          th;
        int          vbefore;
        int          rcyc;

        tbl[0] = '{d: 20,  w: 400,  count: 20'd400,   to: 1'b0};
        tbl[1] = '{d: 0,   w: 0,    count: 20'hFFFFF, to: 1'b1};
        tbl[2] = '{d: 20,  w: 1500, count: 20'hFFFFF, to: 1'b1};
        tbl[3] = '{d: 97,  w: 50,   count: 20'd50,    to: 1'b0};
        tbl[4] = '{d: 98,  w: 50,   count: 20'hFFFFF, to: 1'b1};
        tbl[5] = '{d: -5,  w: 30,   count: 20'd27,    to: 1'b0};
        tbl[6] = '{d: 10,  w: 999,  count: 20'd999,   to: 1'b0};
        tbl[7] = '{d: 10,  w: 1001, count: 20'hFFFFF, to: 1'b1};
        tbl[8] = '{d: 0,   w: 1,    count: 20'd1,     to: 1'b0};
        tbl[9] = '{d: -9,  w: 5,    count: 20'hFFFFF, to: 1'b1};

        rst_n = 1'b0;
        en    = 1'b0;
        echo  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_trig", 32'(trig), 0);
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_busy", 32'(busy), 0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        @(negedge clk);
        check("idle_before_en_trig", 32'(trig), 0);
        check("idle_before_en_busy", 32'(busy), 0);

        // Directed table; each entry is one full measurement cycle
        for (int i = 0; i < 10; i++) begin
            run_meas(tbl[i].d, tbl[i].w, 1'b0, tbl[i].count, tbl[i].to, $sformatf("tbl%0d", i));
        end

        // Random echo placement and width against the reference
        for (int r = 0; r < 6; r++) begin
            d = int'($urandom_range(130, 0)) - 9;
            w = int'($urandom_range(1200, 0));
            model(d, w, mc, mt);
            run_meas(d, w, 1'b0, mc, mt, $sformatf("rnd%0d_d%0d_w%0d", r, d, w));
        end

        // en dropped mid-MEASURE: result still commits, then IDLE at end of period
        run_meas(20, 200, 1'b1, 20'd200, 1'b0, "en_drop");
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("en_drop_idle_reached", 32'(ok), 1);
        check("en_drop_idle_time", cyc - last_rise, PER);
        th = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (trig === 1'b1) th++;
        end
        check("en_drop_no_trig", th, 0);
        check("en_drop_busy", 32'(busy), 0);

        // Reset pulse during MEASURE, then a fresh measurement starts
        @(posedge clk);
        #1 en = 1'b1;
        wait_rise(ok);
        check("rst_seq_trig_rise", 32'(ok), 1);
        repeat (TRIG + 20) @(posedge clk);
        #1 echo = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        echo    = 1'b0;
        vbefore = valid_seen;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        rcyc = cyc;
        check("midrst_trig", 32'(trig), 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_timeout", 32'(timeout), 0);
        check("midrst_busy", 32'(busy), 0);
        wait_rise(ok);
        check("midrst_fresh_trig", 32'(ok), 1);
        check("midrst_fresh_trig_delay", cyc - rcyc, 1);
        check("midrst_no_valid", valid_seen, vbefore);
        check("midrst_count_kept", 32'(count), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
